// File: rtl/in128_out1536_pack_if.sv
// Stream bundle for the 128-bit to 1536-bit packer: one input beat stream and one packed output stream.
// Valid/ready: a beat or word moves on a rising edge where valid and ready are both high; a source keeps data stable while valid is high and ready is low.
interface in128_out1536_pack_if #(
  parameter int DIN_W = 128,
  parameter int RATIO = 12
);
  logic [DIN_W-1:0]       s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic                   s_axis_tlast;
  logic [DIN_W*RATIO-1:0] m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic [RATIO-1:0]       m_axis_tlast;

  // The packer itself: consumes beats, produces words.
  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  // The surrounding system: produces beats, consumes words.
  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/in128_out1536_pack.sv
// Packs RATIO input beats (or fewer, when a packet ends early) into one wide output word,
// marking the lane of the packet-final beat with a one-hot tlast vector.
module in128_out1536_pack #(
  parameter int DIN_W = 128,
  parameter int RATIO = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  in128_out1536_pack_if.slave  bus,
  output logic [15:0]          word_cnt,
  output logic                 dbg_state,
  output logic [3:0]           dbg_cnt
);
  localparam int CNT_W = 4;
  localparam int OUT_W = DIN_W * RATIO;

  // EMIT is a zero-cycle state: it is the edge on which the word moves to the output register.
  typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] pack;
  logic [OUT_W-1:0] next_word;
  logic             accept;
  logic             done;
  logic             out_xfer;

  assign bus.s_axis_tready = ~bus.m_axis_tvalid | bus.m_axis_tready;
  assign accept   = bus.s_axis_tvalid & bus.s_axis_tready;
  assign done     = accept & ((cnt == CNT_W'(RATIO - 1)) | bus.s_axis_tlast);
  assign out_xfer = bus.m_axis_tvalid & bus.m_axis_tready;
  assign state    = done ? EMIT : FILL;

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  // Lanes below cnt come from the pack register, lane cnt from the current beat, the rest stay zero.
  always_comb begin
    next_word = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(cnt)) begin
        next_word[k*DIN_W +: DIN_W] = pack[k*DIN_W +: DIN_W];
      end else if (k == int'(cnt)) begin
        next_word[k*DIN_W +: DIN_W] = bus.s_axis_tdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt               <= '0;
      pack              <= '0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tlast  <= '0;
      word_cnt          <= '0;
    end else begin
      if (out_xfer) begin
        bus.m_axis_tvalid <= 1'b0;
        word_cnt          <= word_cnt + 16'd1;
      end
      // A completing beat overrides the valid clear above, giving back-to-back words.
      if (done) begin
        bus.m_axis_tdata  <= next_word;
        bus.m_axis_tvalid <= 1'b1;
        bus.m_axis_tlast  <= bus.s_axis_tlast ? (RATIO'(1) << cnt) : '0;
        cnt               <= '0;
        pack              <= '0;
      end else if (accept) begin
        pack <= next_word;
        cnt  <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_in128_out1536_pack.sv
// Bench for in128_out1536_pack: table of packet shapes, directed backpressure/reset/latency
// sequences and a 65536-word stream, all checked through an expected-word queue.
module tb_in128_out1536_pack;
  localparam int DW    = 128;
  localparam int RATIO = 12;
  localparam int OW    = DW * RATIO;
  localparam int EW    = OW + RATIO;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] word_cnt;
  logic        dbg_state;
  logic [3:0]  dbg_cnt;

  in128_out1536_pack_if #(.DIN_W(DW), .RATIO(RATIO)) bus ();

  in128_out1536_pack #(.DIN_W(DW), .RATIO(RATIO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .word_cnt  (word_cnt),
    .dbg_state (dbg_state),
    .dbg_cnt   (dbg_cnt)
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [EW-1:0]    exp_q[$];
  logic [OW-1:0]    cur_word = '0;
  int               cur_n = 0;
  logic [15:0]      model_wc = '0;
  int               words_seen = 0;
  logic [RATIO-1:0] last_seen = '0;
  logic             bp_en = 1'b0;
  logic             ready_force = 1'b1;

  typedef struct {
    int               n;
    logic             last;
    logic [DW-1:0]    base;
    logic [RATIO-1:0] exp_last;
    int               exp_words;
  } row_t;
  row_t rows[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_word(input logic [EW-1:0] e);
    int lane;
    n_tests++;
    if (bus.m_axis_tdata !== e[OW-1:0] || bus.m_axis_tlast !== e[EW-1:OW]) begin
      n_fail++;
      lane = 0;
      for (int k = RATIO - 1; k >= 0; k--)
        if (bus.m_axis_tdata[k*DW +: DW] !== e[k*DW +: DW]) lane = k;
      if (n_fail <= 30)
        $display("FAIL word: tlast got %h expected %h; lane %0d got %h expected %h",
                 bus.m_axis_tlast, e[EW-1:OW], lane, bus.m_axis_tdata[lane*DW +: DW], e[lane*DW +: DW]);
    end
  endtask

  // Reference packer: a word is due after 12 beats or at tlast.
  task automatic model_beat(input logic [DW-1:0] d, input logic l);
    logic [RATIO-1:0] tl;
    cur_word[cur_n*DW +: DW] = d;
    if (cur_n == RATIO - 1 || l) begin
      tl = '0;
      if (l) tl[cur_n] = 1'b1;
      exp_q.push_back({tl, cur_word});
      cur_word = '0;
      cur_n = 0;
    end else begin
      cur_n++;
    end
  endtask

  task automatic monitor();
    logic             held = 1'b0;
    logic [OW-1:0]    hd = '0;
    logic [RATIO-1:0] hl = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_wc = '0;
        held = 1'b0;
      end else begin
        check("word_cnt", 64'(word_cnt), 64'(model_wc));
        if (held) begin
          check("hold_tdata", 64'(bus.m_axis_tdata == hd), 64'd1);
          check("hold_tlast", 64'(bus.m_axis_tlast), 64'(hl));
        end
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(bus.m_axis_tlast), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            compare_word(exp_q.pop_front());
          end
          words_seen++;
          last_seen = bus.m_axis_tlast;
          model_wc = model_wc + 16'd1;
        end
        held = bus.m_axis_tvalid && !bus.m_axis_tready;
        hd = bus.m_axis_tdata;
        hl = bus.m_axis_tlast;
      end
    end
  endtask

  task automatic bp_drive();
    forever begin
      @(posedge clk);
      #1;
      bus.m_axis_tready = bp_en ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    logic acc;
    int   b;
    acc = 1'b0;
    b = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    while (!acc && b < 200) begin
      @(negedge clk);
      acc = bus.s_axis_tready;
      @(posedge clk);
      #1;
      b++;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    check("beat_accept", 64'(acc), 64'd1);
    if (acc) model_beat(d, l);
  endtask

  task automatic wait_drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 1000) begin
      @(posedge clk);
      #1;
      b++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    cur_word = '0;
    cur_n = 0;
    repeat (n) begin
      @(negedge clk);
      check("rst_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
      check("rst_s_tready", 64'(bus.s_axis_tready), 64'd1);
      check("rst_word_cnt", 64'(word_cnt), 64'd0);
      check("rst_m_tdata_nonzero", 64'(|bus.m_axis_tdata), 64'd0);
      check("rst_m_tlast", 64'(bus.m_axis_tlast), 64'd0);
      check("rst_cnt", 64'(dbg_cnt), 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int w0;
    int bubbles;
    int stalls;

    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = 1'b1;

    rows[0] = '{12, 1'b1, 128'h0,    12'h800, 1};
    rows[1] = '{5,  1'b1, 128'hA0,   12'h010, 1};
    rows[2] = '{1,  1'b1, 128'hDEAD, 12'h001, 1};
    rows[3] = '{24, 1'b0, 128'h1000, 12'h000, 2};
    rows[4] = '{13, 1'b1, 128'h2000, 12'h001, 2};
    rows[5] = '{5,  1'b0, 128'h3000, 12'h000, 0};
    rows[6] = '{7,  1'b1, 128'h3005, 12'h800, 1};
    rows[7] = '{11, 1'b1, 128'h4000, 12'h400, 1};

    fork
      monitor();
      bp_drive();
    join_none

    do_reset(3);

    // Packet shapes; the first row runs without backpressure.
    for (int r = 0; r < 8; r++) begin
      bp_en = (r != 0);
      w0 = words_seen;
      for (int i = 0; i < rows[r].n; i++)
        send_beat(rows[r].base + DW'(i), rows[r].last && (i == rows[r].n - 1));
      wait_drain();
      repeat (4) @(posedge clk);
      #1;
      check($sformatf("row%0d_words", r), 64'(words_seen - w0), 64'(rows[r].exp_words));
      if (rows[r].exp_words > 0)
        check($sformatf("row%0d_tlast", r), 64'(last_seen), 64'(rows[r].exp_last));
      if (r == 0) begin
        check("row0_word_cnt", 64'(word_cnt), 64'd1);
        check("row0_valid_drop", 64'(bus.m_axis_tvalid), 64'd0);
      end
    end
    bp_en = 1'b0;
    ready_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Word visible one cycle after its acceptance edge.
    send_beat(128'h5555, 1'b1);
    check("latency_valid", 64'(bus.m_axis_tvalid), 64'd1);
    check("latency_lane0", bus.m_axis_tdata[63:0], 64'h5555);
    check("latency_tlast", 64'(bus.m_axis_tlast), 64'h001);
    wait_drain();

    // Stall for 10 cycles, then transfer and accept the next beat on the same edge.
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send_beat(128'hAAAA, 1'b1);
    bus.s_axis_tdata  = 128'hBBBB;
    bus.s_axis_tlast  = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_s_tready", 64'(bus.s_axis_tready), 64'd0);
      check("bp_m_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
      check("bp_m_tdata", bus.m_axis_tdata[63:0], 64'hAAAA);
    end
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_resume_ready", 64'(bus.s_axis_tready), 64'd1);
    @(posedge clk);
    #1;
    model_beat(128'hBBBB, 1'b1);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    check("b2b_valid", 64'(bus.m_axis_tvalid), 64'd1);
    check("b2b_tdata", bus.m_axis_tdata[63:0], 64'hBBBB);
    wait_drain();

    // Reset with a stalled word pending.
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    send_beat(128'hCCCC, 1'b1);
    do_reset(2);
    ready_force = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(bus.m_axis_tvalid), 64'd0);

    // Reset after 7 beats, then a clean 12-beat packet.
    for (int i = 0; i < 7; i++) send_beat(128'hE0 + DW'(i), 1'b0);
    do_reset(2);
    w0 = words_seen;
    for (int i = 0; i < 12; i++) send_beat(128'hB0 + DW'(i), i == 11);
    wait_drain();
    check("rst_pkt_words", 64'(words_seen - w0), 64'd1);
    check("rst_pkt_tlast", 64'(last_seen), 64'h800);

    // One-beat packets every cycle across the word counter wrap.
    do_reset(2);
    w0 = words_seen;
    bubbles = 0;
    stalls = 0;
    bus.s_axis_tlast  = 1'b1;
    bus.s_axis_tvalid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      bus.s_axis_tdata = DW'(i) ^ 128'h1_0000_0000;
      @(negedge clk);
      if (!bus.s_axis_tready) stalls++;
      if (i > 0 && !bus.m_axis_tvalid) bubbles++;
      @(posedge clk);
      #1;
      model_beat(DW'(i) ^ 128'h1_0000_0000, 1'b1);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    wait_drain();
    check("stream_bubbles", 64'(bubbles), 64'd0);
    check("stream_stalls", 64'(stalls), 64'd0);
    check("stream_words", 64'(words_seen - w0), 64'd65536);
    check("wrap_word_cnt", 64'(word_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/in128_out1536_pack.md
IN128_OUT1536_PACK -- requirements
Module: in128_out1536_pack

Interface
REQ-001 SHALL have parameter DIN_W, default 128, meaning the input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 12, meaning input beats per output word (output width = DIN_W*RATIO = 1536).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port s_axis_tdata, input, 128 bits: input beat.
REQ-006 SHALL have port s_axis_tvalid, input, 1 bit: input beat valid.
REQ-007 SHALL have port s_axis_tready, output, 1 bit: input beat accepted when high together with s_axis_tvalid.
REQ-008 SHALL have port s_axis_tlast, input, 1 bit: input beat is the last of its packet.
REQ-009 SHALL have port m_axis_tdata, output, 1536 bits: packed word; lane k = bits [128k+127:128k].
REQ-010 SHALL have port m_axis_tvalid, output, 1 bit: packed word valid.
REQ-011 SHALL have port m_axis_tready, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port m_axis_tlast, output, 12 bits: one-hot lane marker of the packet-final beat; zero if the word has no packet end.
REQ-013 SHALL have port word_cnt, output, 16 bits: count of words accepted downstream.

Function
REQ-014 Handshake: an input beat transfers when s_axis_tvalid & s_axis_tready; an output word transfers when m_axis_tvalid & m_axis_tready.
REQ-015 s_axis_tready SHALL equal ~m_axis_tvalid | m_axis_tready, with no dependence on s_axis_tvalid or s_axis_tlast.
REQ-016 A 4-bit lane counter cnt SHALL select the target lane; an accepted beat is written to lane cnt of the pack register.
REQ-017 States SHALL be FILL (cnt 0..10, accumulating) and EMIT (word being loaded to the output register), with EMIT lasting zero cycles (same-edge transfer).
REQ-018 A word completes on an accepted beat with cnt==11 or s_axis_tlast==1.
REQ-019 On completion, the same edge SHALL perform all of the following:
  - load m_axis_tdata with the pack lanes 0..cnt-1 plus the current beat in lane cnt, and all lanes above cnt zero;
  - set m_axis_tvalid=1;
  - set m_axis_tlast = (1<<cnt) if tlast, else 0;
  - clear cnt and the pack register to 0.
REQ-020 A non-completing accepted beat SHALL increment cnt by 1 and leave the m_axis_* outputs unchanged.
REQ-021 Latency: the completing beat SHALL appear on m_axis_tdata one cycle after its acceptance edge.
REQ-022 m_axis_tvalid SHALL clear on an output transfer unless a new word completes on the same edge, in which case it stays 1 with the new word (back-to-back, no bubble).
REQ-023 While m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata and m_axis_tlast SHALL hold stable and no input SHALL be accepted.
REQ-024 tlast on the 12th beat (cnt==11) SHALL give m_axis_tlast=12'h800 and a full word.
REQ-025 An empty packet (no beats) SHALL produce no word; a partial word is never emitted without tlast.
REQ-026 word_cnt SHALL increment by 1 on each output transfer and wrap 16'hFFFF->0.

Reset
REQ-027 While rst=1 (asynchronously asserted, released synchronously to clk):
  - cnt, the pack register, m_axis_tdata, m_axis_tlast and word_cnt SHALL be 0;
  - m_axis_tvalid SHALL be 0;
  - s_axis_tready SHALL be 1.
REQ-028 Reset mid-packet SHALL discard the partial pack and any pending output word; the first beat after release goes to lane 0.

Verification
REQ-029 Scenario: 12 beats with data=i (i=0..11), tlast only on i=11, m_axis_tready=1 -> one word with lane k=k, m_axis_tlast=12'h800, m_axis_tvalid high for 1 cycle, word_cnt=1.
REQ-030 Scenario: 5 beats A0..A4 with tlast on A4 -> lanes 0..4=A0..A4, lanes 5..11=0, m_axis_tlast=12'h010; the next beat lands in lane 0.
REQ-031 Scenario: single beat 0xDEAD with tlast -> lane0=0xDEAD, rest zero, m_axis_tlast=12'h001.
REQ-032 Scenario: word pending with m_axis_tready=0 for 10 cycles -> s_axis_tready=0 and outputs stable throughout; after tready rises, the transfer occurs and input resumes the next cycle.
REQ-033 Scenario: continuous 1-beat tlast packets with m_axis_tready=1 -> one word per cycle with no bubbles; word_cnt counts 65536 words and wraps to 0.
REQ-034 Scenario: rst pulse after 7 beats, then 12 beats B0..B11 -> m_axis_tvalid=0 during reset; the first word is B0..B11 with no pre-reset data.
